hamming_ordered_merge: RTL

//  Two-input ordered merge stage for the Hamming-number stream pipeline.
//  - Consumes two ascending word streams via the reader side of two upstream ping-pong FIFOs.
//  - Produces their ascending union, duplicates removed by default, via the writer side of one downstream ping-pong FIFO.
//  - Sits between the x2/x3/x5 scale stages' FIFOs and the FIFO feeding the next merge or the sink.

---
 rtl/hamming_stream_pkg.sv | 19 +
 rtl/hs_reader_port.sv | 66 ++++++
 rtl/hamming_ordered_merge.sv | 110 +++++++++++
 3 files changed

// File: rtl/hamming_stream_pkg.sv
// Shared types for the Hamming-number stream pipeline.
//   word_t          default 16-bit stream word
//   hs_state_t      four-phase handshake port states
//   HS_RESET_STATE  state every handshake port returns to on reset/clear
package hamming_stream_pkg;

  localparam int WORD_WIDTH = 16;

  typedef logic [WORD_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    HS_IDLE    = 2'd0,
    HS_REQ     = 2'd1,
    HS_RELEASE = 2'd2
  } hs_state_t;

  localparam hs_state_t HS_RESET_STATE = HS_IDLE;

endpackage

// File: rtl/hs_reader_port.sv
// Reader side of one four-phase handshake link to an upstream FIFO.
// Keeps a one-word head register that the merge logic inspects and consumes.
//   clock, reset_n, clear   clocking, sync active-low reset, sync flush
//   consume                 pulse: the merge has taken the current head
//   get_req/get_ack         four-phase handshake with the upstream FIFO
//   get_value               upstream word, valid while get_ack is high
//   head, head_valid        buffered word presented to the merge logic
module hs_reader_port
  import hamming_stream_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             consume,
  output logic             get_req,
  input  logic             get_ack,
  input  logic [WIDTH-1:0] get_value,
  output logic [WIDTH-1:0] head,
  output logic             head_valid
);

  hs_state_t state, state_next;

  // Handshake state register; reset and clear both drop the link back to
  // idle so any request in flight is withdrawn on that same edge.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      state <= HS_RESET_STATE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A fetch is only started when the head is empty and the
  // previous acknowledge has been released, which also keeps a stale ack that
  // is still high after reset from being mistaken for a new transfer.
  always_comb begin
    state_next = state;
    case (state)
      HS_IDLE:    if (!head_valid && !get_ack) state_next = HS_REQ;
      HS_REQ:     if (get_ack) state_next = HS_RELEASE;
      HS_RELEASE: if (!get_ack) state_next = HS_IDLE;
      default:    state_next = HS_RESET_STATE;
    endcase
  end

  assign get_req = (state == HS_REQ);

  // Head register: loaded on the acknowledge edge, emptied when the merge
  // consumes it. Capture and consume can never coincide because a request is
  // only outstanding while the head is empty.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      head       <= '0;
      head_valid <= 1'b0;
    end else if (state == HS_REQ && get_ack) begin
      head       <= get_value;
      head_valid <= 1'b1;
    end else if (consume) begin
      head_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/hamming_ordered_merge.sv
// Two-input ordered merge: emits the ascending union of two ascending word
// streams, optionally collapsing equal heads into one output word.
//   clock, reset_n, clear      clocking, sync active-low reset, sync flush
//   a_get_* / b_get_*          reader handshakes to the two upstream FIFOs
//   put_req/put_ack/put_value  writer handshake to the downstream FIFO
//   merged_count               words accepted downstream (wraps at 2^32)
module hamming_ordered_merge
  import hamming_stream_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter bit DEDUP = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  output logic             a_get_req,
  input  logic             a_get_ack,
  input  logic [WIDTH-1:0] a_get_value,
  output logic             b_get_req,
  input  logic             b_get_ack,
  input  logic [WIDTH-1:0] b_get_value,
  output logic             put_req,
  input  logic             put_ack,
  output logic [WIDTH-1:0] put_value,
  output logic [31:0]      merged_count
);

  logic [WIDTH-1:0] a_head, b_head;
  logic             a_valid, b_valid;
  logic             select, take_a, take_b;
  hs_state_t        put_state, put_state_next;
  logic [31:0]      count_q;

  hs_reader_port #(.WIDTH(WIDTH)) u_port_a (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (clear),
    .consume    (take_a),
    .get_req    (a_get_req),
    .get_ack    (a_get_ack),
    .get_value  (a_get_value),
    .head       (a_head),
    .head_valid (a_valid)
  );

  hs_reader_port #(.WIDTH(WIDTH)) u_port_b (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (clear),
    .consume    (take_b),
    .get_req    (b_get_req),
    .get_ack    (b_get_ack),
    .get_value  (b_get_value),
    .head       (b_head),
    .head_valid (b_valid)
  );

  // Selection: a word is chosen only when both heads are known and the
  // writer link is fully idle. On a tie A is always taken; B is taken too
  // only when duplicates are being collapsed, otherwise B waits for the next
  // selection. Consumed heads start refetching while the put is in flight.
  always_comb begin
    select = a_valid && b_valid && (put_state == HS_IDLE) && !put_ack;
    take_a = select && (a_head <= b_head);
    take_b = select && ((b_head < a_head) || (DEDUP && (a_head == b_head)));
  end

  // Writer handshake state register.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      put_state <= HS_RESET_STATE;
    end else begin
      put_state <= put_state_next;
    end
  end

  // Writer next-state logic: raise on selection, hold until acknowledged,
  // then wait for the acknowledge to drop before another word can go out.
  always_comb begin
    put_state_next = put_state;
    case (put_state)
      HS_IDLE:    if (select) put_state_next = HS_REQ;
      HS_REQ:     if (put_ack) put_state_next = HS_RELEASE;
      HS_RELEASE: if (!put_ack) put_state_next = HS_IDLE;
      default:    put_state_next = HS_RESET_STATE;
    endcase
  end

  assign put_req = (put_state == HS_REQ);

  // Output word and accepted-word counter. The word only changes on a
  // selection, which cannot happen while a put is pending, so it stays
  // stable for the whole request phase.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      put_value <= '0;
      count_q   <= '0;
    end else begin
      if (select) begin
        put_value <= take_a ? a_head : b_head;
      end
      if (put_state == HS_REQ && put_ack) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  assign merged_count = count_q;

endmodule
